// File: rtl/extmem_pkg.sv
// Shared definitions for the external-bus memory responder: FSM states, extsz
// line encodings, requester codes and small decode helpers.
package extmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWbeat2,
    StWait,
    StReply
  } ext_state_e;

  localparam logic [4:0] SzLine16 = 5'd15;
  localparam logic [4:0] SzLine32 = 5'd31;

  localparam logic SrcDcache = 1'b1;
  localparam logic SrcIcache = 1'b0;

  // Line writes only exist for 16-byte lines; 32-byte lines are read-only.
  function automatic logic sz_legal(input logic [4:0] sz, input logic wr);
    return (sz <= 5'd7) || (sz == SzLine16) || ((sz == SzLine32) && !wr);
  endfunction

  function automatic logic [1:0] last_beat(input logic [4:0] sz);
    if (sz == SzLine32) return 2'd3;
    if (sz == SzLine16) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/extmem_merge.sv
// Byte-lane merge for partial writes: big-endian within the doubleword, the
// MSB of the (sz+1)-byte field lands at the lowest address; overflow bytes drop.
module extmem_merge (
  input  logic [63:0] i_old,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_sz,
  output logic [63:0] o_new
);

  always_comb begin
    o_new = i_old;
    for (int k = 0; k < 8; k++) begin
      if ((k <= int'(i_sz)) && ((int'(i_off) + k) <= 7)) begin
        o_new[8*(7 - (int'(i_off) + k)) +: 8] = i_wdata[8*(int'(i_sz) - k) +: 8];
      end
    end
  end

endmodule

// File: rtl/extmem.sv
// Memory-side responder terminating the ext* request bus; single outstanding request.
// Optional address/size checking with sticky exterr is enabled by EXTMEM_ADDRCHK_EN.
module extmem
  import extmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LAT       = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        phi2,
  input  logic [31:0] extaddr,
  input  logic [63:0] extwdata,
  input  logic [4:0]  extsz,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterr
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  ext_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_dw;
  logic [4:0]    r_sz;
  logic          r_src;
  logic          r_oor;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_beat, w_beat_nxt, w_rd_beat;
  logic          r_reply, w_reply_nxt;
  logic [63:0]   r_rdata, w_rdata_nxt;
  logic [63:0]   r_mem [MEM_WORDS];

  logic          w_accept, w_oor, w_sz_ok, w_we, w_err_set;
  logic [AW-1:0] w_widx, w_rd_idx;
  logic [63:0]   w_wdata, w_merged, w_rd_data;

  assign extrdy     = rstn && (r_state == StIdle);
  assign w_accept   = extreq && extrdy;
  assign w_sz_ok    = sz_legal(extsz, extwr);
  assign extreply   = r_reply;
  assign extreplyto = r_src;
  assign extrdata   = r_rdata;

`ifdef EXTMEM_ADDRCHK_EN
  assign w_oor = (extaddr >> (AW + 3)) != 32'd0;
`else
  assign w_oor = 1'b0;
`endif

  extmem_merge u_merge (
    .i_old   (r_mem[extaddr[AW+2:3]]),
    .i_wdata (extwdata),
    .i_off   (extaddr[2:0]),
    .i_sz    (extsz[2:0]),
    .o_new   (w_merged)
  );

  // Beat about to be presented: 0 when leaving WAIT, else the one after r_beat.
  assign w_rd_beat = (r_state == StReply) ? r_beat + 2'd1 : 2'd0;

  always_comb begin
    unique case (r_sz)
      SzLine32: w_rd_idx = {r_dw[AW-1:2], w_rd_beat};
      SzLine16: w_rd_idx = {r_dw[AW-1:1], r_dw[0] ^ w_rd_beat[0]};
      default:  w_rd_idx = r_dw;
    endcase
  end

  assign w_rd_data = r_oor ? 64'h0 : r_mem[w_rd_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_reply_nxt = 1'b0;
    w_rdata_nxt = r_rdata;
    w_we        = 1'b0;
    w_widx      = extaddr[AW+2:3];
    w_wdata     = w_merged;
    w_err_set   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!w_sz_ok) begin
            w_err_set = 1'b1;
          end else begin
            w_err_set = w_oor;
            if (!extwr) begin
              w_state_nxt = StWait;
              w_cnt_nxt   = '0;
            end else begin
              w_we = !w_oor;
              if (extsz == SzLine16) begin
                w_widx      = {extaddr[AW+2:4], 1'b0};
                w_wdata     = extwdata;
                w_state_nxt = StWbeat2;
              end
            end
          end
        end
      end
      StWbeat2: begin
        w_we        = !r_oor;
        w_widx      = {r_dw[AW-1:1], 1'b1};
        w_wdata     = extwdata;
        w_state_nxt = StIdle;
      end
      StWait: begin
        if (r_cnt == CW'(LAT - 1)) begin
          w_state_nxt = StReply;
          w_reply_nxt = 1'b1;
          w_beat_nxt  = w_rd_beat;
          w_rdata_nxt = w_rd_data;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StReply: begin
        if (r_beat == last_beat(r_sz)) begin
          w_state_nxt = StIdle;
        end else begin
          w_reply_nxt = 1'b1;
          w_beat_nxt  = w_rd_beat;
          w_rdata_nxt = w_rd_data;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_reply <= 1'b0;
      r_rdata <= '0;
      r_src   <= 1'b0;
      r_dw    <= '0;
      r_sz    <= '0;
      r_oor   <= 1'b0;
    end else if (phi2) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beat  <= w_beat_nxt;
      r_reply <= w_reply_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_accept) begin
        r_dw  <= extaddr[AW+2:3];
        r_sz  <= extsz;
        r_src <= extsrc;
        r_oor <= w_oor;
      end
    end
  end

  // Gating on rstn keeps a reset from landing the second beat of a line write.
  always_ff @(posedge clk) begin
    if (rstn && phi2 && w_we) begin
      r_mem[w_widx] <= w_wdata;
    end
  end

`ifdef EXTMEM_ADDRCHK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (phi2 && w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign exterr = r_err;
`else
  logic w_unused;

  assign w_unused = ^{w_err_set, extaddr[31:AW+3]};
  assign exterr   = 1'b0;
`endif

endmodule

// File: tb/tb_extmem.sv
// Randomised bench for extmem against a byte-addressed reference model of the
// backing store and the reply timing (first beat LAT phi2 edges after acceptance).
module tb_extmem;

  localparam int unsigned MEM_WORDS = 4096;
  localparam int          LAT       = 2;
`ifdef EXTMEM_ADDRCHK_EN
  localparam bit ADDRCHK = 1'b1;
`else
  localparam bit ADDRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn, phi2, extreq, extwr, extsrc;
  logic [31:0] extaddr;
  logic [63:0] extwdata;
  logic [4:0]  extsz;
  logic        extrdy, extreply, extreplyto, exterr;
  logic [63:0] extrdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mdl_mem [MEM_WORDS];
  bit          mdl_err = 1'b0;

  extmem #(
    .MEM_WORDS (MEM_WORDS),
    .LAT       (LAT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .phi2       (phi2),
    .extaddr    (extaddr),
    .extwdata   (extwdata),
    .extsz      (extsz),
    .extreq     (extreq),
    .extwr      (extwr),
    .extsrc     (extsrc),
    .extrdy     (extrdy),
    .extreply   (extreply),
    .extreplyto (extreplyto),
    .extrdata   (extrdata),
    .exterr     (exterr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Inputs change at the negedge; outputs are sampled at the following negedge.
  task automatic cycle(input bit p);
    phi2 = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit rand_phi2();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic wait_phi2_edge();
    bit p = 1'b0;
    int tries = 0;
    while (!p) begin
      p = (tries >= 8) ? 1'b1 : rand_phi2();
      cycle(p);
      tries++;
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 3) % MEM_WORDS;
  endfunction

  function automatic bit addr_oor(input logic [31:0] a);
    return ADDRCHK && (a >= 32'(MEM_WORDS * 8));
  endfunction

  task automatic mdl_write(input logic [31:0] a, input int sz, input logic [63:0] wd);
    logic [63:0] t;
    int o;
    t = mdl_mem[widx(a)];
    for (int k = 0; k <= sz; k++) begin
      o = int'(a[2:0]) + k;
      if (o <= 7) t[8*(7-o) +: 8] = wd[8*(sz-k) +: 8];
    end
    mdl_mem[widx(a)] = t;
  endtask

  task automatic do_req(input bit wr, input bit src, input logic [31:0] addr,
                        input logic [4:0] sz, input logic [63:0] wd0, input logic [63:0] wd1,
                        input bit hold, input int abort_beat);
    bit          legal, oor, p, in_beat;
    int          nb, edges;
    logic [31:0] ba [4];
    logic [63:0] exp_beat [4];

    check_eq("rdy_idle", extrdy, 1);
    extreq = 1'b1; extwr = wr; extsrc = src; extaddr = addr; extsz = sz; extwdata = wd0;
    wait_phi2_edge();
    legal = (sz <= 5'd7) || (sz == 5'd15) || ((sz == 5'd31) && !wr);
    oor   = addr_oor(addr);
    extreq = hold;
    if (hold) extsrc = !src;

    if (!legal) begin
      if (ADDRCHK) mdl_err = 1'b1;
    end else if (wr) begin
      if (oor) mdl_err = 1'b1;
      check_eq("wr_noreply", extreply, 0);
      if (sz == 5'd15) begin
        check_eq("rdy_wbeat2", extrdy, 0);
        extreq = 1'b1;
        extwdata = wd1;
        wait_phi2_edge();
        extreq = hold;
        check_eq("wr2_noreply", extreply, 0);
        if (!oor) begin
          mdl_mem[widx(addr & ~32'hF)]         = wd0;
          mdl_mem[widx((addr & ~32'hF) + 8)]   = wd1;
        end
      end else if (!oor) begin
        mdl_write(addr, int'(sz), wd0);
      end
    end else begin
      if (oor) mdl_err = 1'b1;
      if (sz == 5'd31) begin
        nb = 4;
        for (int k = 0; k < 4; k++) ba[k] = (addr & ~32'h1F) + 32'(8 * k);
      end else if (sz == 5'd15) begin
        nb = 2;
        ba[0] = addr & ~32'h7;
        ba[1] = ba[0] ^ 32'h8;
      end else begin
        nb = 1;
        ba[0] = addr & ~32'h7;
      end
      for (int k = 0; k < nb; k++) exp_beat[k] = oor ? 64'h0 : mdl_mem[widx(ba[k])];

      check_eq("rdy_busy", extrdy, 0);
      edges = 0;
      while (edges < LAT + nb) begin
        p = rand_phi2();
        cycle(p);
        if (p) edges++;
        in_beat = (edges >= LAT) && (edges < LAT + nb);
        check_eq("reply_valid", extreply, in_beat);
        if (in_beat) begin
          check_eq("reply_data", extrdata, exp_beat[edges-LAT]);
          check_eq("reply_to", extreplyto, src);
        end
        if (edges < LAT + nb) check_eq("rdy_busy", extrdy, 0);
        if (in_beat && (abort_beat >= 0) && (edges - LAT == abort_beat)) begin
          rstn = 1'b0;
          extreq = 1'b0;
          cycle(1'b1);
          check_eq("rst_reply", extreply, 0);
          check_eq("rst_rdata", extrdata, 0);
          check_eq("rst_replyto", extreplyto, 0);
          check_eq("rst_rdy_low", extrdy, 0);
          check_eq("rst_err", exterr, 0);
          rstn = 1'b1;
          mdl_err = 1'b0;
          #1;
          check_eq("rst_rdy_release", extrdy, 1);
          return;
        end
      end
      check_eq("rdy_after", extrdy, 1);
    end
    check_eq("err", exterr, mdl_err);
  endtask

  initial begin
    logic [31:0] a;
    logic [4:0]  sz;
    int          r;

    rstn = 1'b0; phi2 = 1'b1; extreq = 1'b0; extwr = 1'b0; extsrc = 1'b0;
    extaddr = '0; extwdata = '0; extsz = '0;
    cycle(1'b1);
    cycle(1'b0);
    check_eq("reset_rdy", extrdy, 0);
    check_eq("reset_reply", extreply, 0);
    check_eq("reset_replyto", extreplyto, 0);
    check_eq("reset_rdata", extrdata, 0);
    check_eq("reset_err", exterr, 0);
    rstn = 1'b1;
    #1;
    check_eq("reset_rdy_release", extrdy, 1);

    // Known contents for the window the bench reads from.
    for (int i = 0; i < 256; i++) do_req(1'b1, 1'b1, 32'(i * 8), 5'd7, 64'h0, 64'h0, 1'b0, -1);

    // Partial big-endian write then full-doubleword read.
    do_req(1'b1, 1'b1, 32'h104, 5'd3, 64'hDEAD_BEEF, 64'h0, 1'b0, -1);
    do_req(1'b0, 1'b1, 32'h100, 5'd7, 64'h0, 64'h0, 1'b0, -1);

    // Critical-doubleword-first 16-byte line read.
    do_req(1'b1, 1'b1, 32'h200, 5'd7, 64'hAAAA_0000_1111_2222, 64'h0, 1'b0, -1);
    do_req(1'b1, 1'b1, 32'h208, 5'd7, 64'hBBBB_3333_4444_5555, 64'h0, 1'b0, -1);
    do_req(1'b0, 1'b1, 32'h208, 5'd15, 64'h0, 64'h0, 1'b0, -1);

    // 32-byte line read always in order 0..3.
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 1'b1, 32'h300 + 32'(8 * i), 5'd7, {$urandom, $urandom}, 64'h0, 1'b0, -1);
    do_req(1'b0, 1'b0, 32'h310, 5'd31, 64'h0, 64'h0, 1'b0, -1);

    // Two-beat line write, then read both halves.
    do_req(1'b1, 1'b1, 32'h400, 5'd15, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, -1);
    do_req(1'b0, 1'b1, 32'h400, 5'd7, 64'h0, 64'h0, 1'b0, -1);
    do_req(1'b0, 1'b0, 32'h408, 5'd7, 64'h0, 64'h0, 1'b0, -1);

    // Icache request held high across a dcache read.
    do_req(1'b0, 1'b1, 32'h100, 5'd7, 64'h0, 64'h0, 1'b1, -1);
    do_req(1'b0, 1'b0, 32'h208, 5'd15, 64'h0, 64'h0, 1'b0, -1);

    // Reset during the second beat of a 32-byte read, then recovery.
    do_req(1'b0, 1'b1, 32'h308, 5'd31, 64'h0, 64'h0, 1'b0, 1);
    do_req(1'b0, 1'b1, 32'h300, 5'd31, 64'h0, 64'h0, 1'b0, -1);

    // Illegal sizes leave memory untouched.
    do_req(1'b1, 1'b1, 32'h100, 5'd31, 64'h1111_2222_3333_4444, 64'h0, 1'b0, -1);
    do_req(1'b1, 1'b1, 32'h100, 5'd9, 64'h5555_6666_7777_8888, 64'h0, 1'b0, -1);
    do_req(1'b0, 1'b1, 32'h100, 5'd7, 64'h0, 64'h0, 1'b0, -1);

    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 32'h7FF);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_8000);
      r = $urandom_range(0, 9);
      sz = (r < 8) ? 5'(r) : ((r == 8) ? 5'd15 : 5'd31);
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz,
             {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
